// File: rtl/button_input.sv
// Debounced push-button front end: per-channel synchronizer, hold counter,
// sticky press flags and a single-cycle press interrupt.
module button_input #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 27000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] interrupt_enable,
  input  logic               clear_enable,
  input  logic [NUM_BTN-1:0] clear_mask,
  output logic [NUM_BTN-1:0] state,
  output logic [NUM_BTN-1:0] status,
  output logic               interrupt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [NUM_BTN-1:0] sync_q1;
  logic [NUM_BTN-1:0] sync_q2;
  logic [NUM_BTN-1:0] synced;
  logic [NUM_BTN-1:0] differ;
  logic [NUM_BTN-1:0] accept;
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] clr;
  logic [NUM_BTN-1:0] state_d;
  logic [NUM_BTN-1:0] status_d;
  logic               irq_d;
  logic [CW-1:0]      cnt_q [NUM_BTN];
  logic [CW-1:0]      cnt_d [NUM_BTN];

  // Pins idle high; loading 1 keeps reset from looking like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '1;
      sync_q2 <= '1;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  assign synced = ~sync_q2;
  assign differ = synced ^ state;

  always_comb begin
    accept = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i] = '0;
      accept[i] = differ[i] && (cnt_q[i] == CNT_MAX);
      unique case (1'b1)
        !differ[i]: cnt_d[i] = '0;
        accept[i]:  cnt_d[i] = '0;
        default:    cnt_d[i] = cnt_q[i] + CNT_ONE;
      endcase
    end
  end

  // Only rising edges of the debounced level count as events.
  always_comb begin
    state_d  = state ^ accept;
    press    = accept & synced;
    clr      = clear_enable ? clear_mask : '0;
    status_d = (status & ~clr) | press;
    irq_d    = |(press & interrupt_enable);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= '0;
      status    <= '0;
      interrupt <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state     <= state_d;
      status    <= status_d;
      interrupt <= irq_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_button_input.sv
// Bench for button_input: vector table, corner sequences and random
// stimulus compared against a sliding-window debounce model.
module tb_button_input;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_raw = '1;
  logic [N-1:0] interrupt_enable = '0;
  logic         clear_enable = 1'b0;
  logic [N-1:0] clear_mask = '0;
  logic [N-1:0] state;
  logic [N-1:0] status;
  logic         interrupt;

  button_input #(.NUM_BTN(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .interrupt_enable(interrupt_enable),
    .clear_enable(clear_enable),
    .clear_mask(clear_mask),
    .state(state),
    .status(status),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int npulse = 0;

  // Model: state flips once the last D synced samples all disagree with it.
  logic [N-1:0] m_s1, m_s2, m_st, m_status;
  logic         m_int;
  logic [D-1:0] m_win [N];

  typedef struct {
    logic         r;
    logic [N-1:0] raw;
    logic [N-1:0] ie;
    logic         ce;
    logic [N-1:0] cm;
    logic [N-1:0] e_state;
    logic [N-1:0] e_status;
    logic         e_int;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [N-1:0] raw, logic [N-1:0] ie,
                              logic [N-1:0] es, logic [N-1:0] est,
                              logic ei);
    vec_t v;
    v.r = r; v.raw = raw; v.ie = ie; v.ce = 1'b0; v.cm = '0;
    v.e_state = es; v.e_status = est; v.e_int = ei;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic [N-1:0] raw,
                            input logic [N-1:0] ie, input logic ce,
                            input logic [N-1:0] cm);
    logic [N-1:0] syn, prs, nst;
    if (r) begin
      m_s1 = '1; m_s2 = '1; m_st = '0; m_status = '0; m_int = 1'b0;
      for (int i = 0; i < N; i++) m_win[i] = '0;
    end else begin
      syn = ~m_s2;
      prs = '0;
      nst = m_st;
      for (int i = 0; i < N; i++) begin
        m_win[i] = {m_win[i][D-2:0], syn[i]};
        if (m_win[i] == {D{~m_st[i]}}) begin
          nst[i] = ~m_st[i];
          prs[i] = nst[i];
        end
      end
      m_int = |(prs & ie);
      m_status = (m_status & ~(ce ? cm : '0)) | prs;
      m_st = nst;
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  task automatic cyc(input logic r, input logic [N-1:0] raw,
                     input logic [N-1:0] ie, input logic ce,
                     input logic [N-1:0] cm);
    rst = r;
    btn_raw = raw;
    interrupt_enable = ie;
    clear_enable = ce;
    clear_mask = cm;
    @(posedge clk);
    model_edge(r, raw, ie, ce, cm);
    #1;
    if (interrupt === 1'b1) npulse++;
    chk("model_state", 8'(state), 8'(m_st));
    chk("model_status", 8'(status), 8'(m_status));
    chk("model_int", 8'(interrupt), 8'(m_int));
  endtask

  task automatic do_reset();
    cyc(1'b1, '1, '0, 1'b0, '0);
    cyc(1'b1, '1, '0, 1'b0, '0);
  endtask

  initial begin
    logic [N-1:0] raw_r;
    logic         rr;

    // Single press, then bounce on another channel.
    tbl.push_back(mk(1, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 0));
    for (int k = 1; k <= 5; k++)
      tbl.push_back(mk(0, 4'b1110, 4'b0001, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1110, 4'b0001, 4'b0001, 4'b0001, 1));
    tbl.push_back(mk(0, 4'b1110, 4'b0001, 4'b0001, 4'b0001, 0));
    tbl.push_back(mk(0, 4'b1110, 4'b0001, 4'b0001, 4'b0001, 0));
    tbl.push_back(mk(1, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 4'b1101, 4'b1111, 4'b0000, 4'b0000, 0));
    tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 4'b1101, 4'b1111, 4'b0000, 4'b0000, 0));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 0));

    foreach (tbl[k]) begin
      cyc(tbl[k].r, tbl[k].raw, tbl[k].ie, tbl[k].ce, tbl[k].cm);
      chk("tbl_state", 8'(state), 8'(tbl[k].e_state));
      chk("tbl_status", 8'(status), 8'(tbl[k].e_status));
      chk("tbl_int", 8'(interrupt), 8'(tbl[k].e_int));
    end

    // Simultaneous presses on two enabled channels.
    do_reset();
    npulse = 0;
    repeat (5) cyc(0, 4'b1010, 4'b0101, 0, '0);
    cyc(0, 4'b1010, 4'b0101, 0, '0);
    chk("dual_status", 8'(status), 8'h05);
    chk("dual_int", 8'(interrupt), 8'h1);
    repeat (6) cyc(0, 4'b1010, 4'b0101, 0, '0);
    chk("dual_pulses", 8'(npulse), 8'd1);

    // Clear behaviour, including set-wins on the press cycle.
    do_reset();
    cyc(0, 4'b1110, '0, 0, '0);
    repeat (6) cyc(0, 4'b1100, '0, 0, '0);
    chk("clr_pre", 8'(status), 8'h03);
    cyc(0, 4'b1100, '0, 1, 4'b0001);
    chk("clr_bit0", 8'(status), 8'h02);
    repeat (6) cyc(0, 4'b1110, '0, 0, '0);
    chk("clr_rel_state", 8'(state), 8'h01);
    repeat (5) cyc(0, 4'b1100, '0, 0, '0);
    cyc(0, 4'b1100, '0, 1, 4'b0010);
    chk("clr_setwins_state", 8'(state), 8'h03);
    chk("clr_setwins_status", 8'(status), 8'h02);

    // Disabled channel: status only, release keeps status.
    do_reset();
    npulse = 0;
    repeat (6) cyc(0, 4'b0111, '0, 0, '0);
    chk("dis_state", 8'(state), 8'h08);
    chk("dis_status", 8'(status), 8'h08);
    cyc(0, 4'b0111, 4'b1000, 0, '0);
    repeat (6) cyc(0, 4'b1111, 4'b1000, 0, '0);
    chk("dis_rel_state", 8'(state), 8'h00);
    chk("dis_rel_status", 8'(status), 8'h08);
    chk("dis_pulses", 8'(npulse), 8'd0);

    // Reset in the middle of a count, button held through it.
    do_reset();
    repeat (4) cyc(0, 4'b1110, 4'b0001, 0, '0);
    cyc(1, 4'b1110, 4'b0001, 0, '0);
    cyc(1, 4'b1110, 4'b0001, 0, '0);
    chk("rst_state", 8'(state), 8'h00);
    chk("rst_status", 8'(status), 8'h00);
    chk("rst_int", 8'(interrupt), 8'h0);
    repeat (5) cyc(0, 4'b1110, 4'b0001, 0, '0);
    chk("rst_early", 8'(state), 8'h00);
    cyc(0, 4'b1110, 4'b0001, 0, '0);
    chk("rst_late_state", 8'(state), 8'h01);
    chk("rst_late_status", 8'(status), 8'h01);
    chk("rst_late_int", 8'(interrupt), 8'h1);

    // Random activity against the model.
    raw_r = '1;
    repeat (800) begin
      if ($urandom_range(0, 5) == 0)
        raw_r[$urandom_range(0, N - 1)] ^= 1'b1;
      rr = ($urandom_range(0, 149) == 0);
      cyc(rr, raw_r, N'($urandom), ($urandom_range(0, 7) == 0),
          N'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_input.md
BUTTON_INPUT -- requirements
Module: button_input

Interface
REQ-001 Parameter NUM_BTN, default 4, number of independent button channels (1..8).
REQ-002 Parameter DEBOUNCE_CYCLES, default 27000, clk cycles the synchronized input must hold a new level before it is accepted (>= 2).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 btn_raw  input  NUM_BTN  asynchronous board pins, active-low (0 = pressed).
REQ-007 interrupt_enable  input  NUM_BTN  per-channel enable for interrupt generation.
REQ-008 clear_enable  input  1  when high, clears status bits selected by clear_mask.
REQ-009 clear_mask  input  NUM_BTN  status bits to clear.
REQ-010 state  output  NUM_BTN  debounced level, active-high (1 = pressed).
REQ-011 status  output  NUM_BTN  sticky press-event flags.
REQ-012 interrupt  output  1  registered single-cycle press interrupt pulse toward the interrupt block.

Function
REQ-013 Each btn_raw bit SHALL pass through a 2-flop synchronizer, then be inverted to active-high ("synced").
REQ-014 Each channel SHALL own a counter of width clog2(DEBOUNCE_CYCLES).
REQ-015 synced == state bit: counter SHALL be 0 on the next edge.
REQ-016 synced != state bit and counter < DEBOUNCE_CYCLES-1: counter SHALL increment.
REQ-017 synced != state bit and counter == DEBOUNCE_CYCLES-1: state bit SHALL take synced and counter SHALL return to 0 on that edge.
REQ-018 Latency: a raw change first sampled at edge 1 and held SHALL appear on state after edge DEBOUNCE_CYCLES+2; any reversion before then restarts the count from 0.
REQ-019 Press event = state bit going 0->1; release events (1->0) SHALL NOT affect status or interrupt.
REQ-020 A press event SHALL set the status bit on the same edge state updates.
REQ-021 clear_enable with clear_mask bit set SHALL clear that status bit on the next edge; bits not in clear_mask are unchanged.
REQ-022 Press event and clear on the same bit in the same cycle: set SHALL win (status = 1).
REQ-023 interrupt SHALL be 1 for exactly one cycle, on the edge state updates, when at least one channel has a press event with its interrupt_enable bit high; otherwise 0.
REQ-024 Simultaneous press events on several enabled channels SHALL produce one single-cycle pulse; status records every channel.
REQ-025 interrupt_enable low SHALL still record status; no pulse is produced later if enable rises afterwards.
REQ-026 Channels are fully independent; no priority or shared counter.

Reset
REQ-027 While rst is high at an edge: synchronizer flops SHALL load 1 (released), counters 0, state 0, status 0, interrupt 0.
REQ-028 Reset mid-debounce SHALL discard the partial count; no press event SHALL be generated from pre-reset activity.
REQ-029 A button held low through reset release SHALL be reported as a press after the full REQ-018 latency counted from the first post-reset edge.

Verification (DEBOUNCE_CYCLES = 4, NUM_BTN = 4)
REQ-030 btn_raw[0] 1->0 held, interrupt_enable=4'b0001 -> state=4'b0001, status=4'b0001, interrupt=1 for one cycle, all after edge 6; interrupt 0 after edge 7.
REQ-031 btn_raw[1] low 3 cycles, high 1, low 3 (bounce) -> state, status, interrupt stay 0 throughout.
REQ-032 btn_raw[0] and btn_raw[2] pressed same cycle, interrupt_enable=4'b0101 -> status=4'b0101, exactly one interrupt pulse.
REQ-033 status=4'b0011, clear_enable=1, clear_mask=4'b0001 -> status=4'b0010 next cycle; then clear bit 1 on the press-event cycle of channel 1 -> status bit 1 remains 1.
REQ-034 Button 3 pressed with interrupt_enable=0 -> status[3]=1, interrupt stays 0; release -> state[3]=0, status[3] stays 1.
REQ-035 rst asserted at count 2 of a press, button held -> outputs 0 during reset; press reported at edge 6 after reset release.
